// File: rtl/adder_share_arb.sv
// adder_share_arb
//   Round-robin front end that lets NUM_REQ requesters share one external
//   fixed-latency pipelined adder. Each issued op carries its requester ID
//   down a valid/ID pipe that mirrors the adder latency, so the sum is routed
//   back to the requester that issued it. A flush request stops new grants,
//   lets in-flight ops finish, and pulses flush_done once the pipe is empty.
//
//   Optional feature macro: GRANT_CNT_EN
//     defined   -> adds output grant_cnt with one 16-bit wrapping grant counter
//                  per requester. The counters clear on reset and on entry to
//                  the FLUSHED state.
//     undefined -> the port and the counters are absent.
module adder_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64,
   parameter int ADD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_x,
   input  logic [NUM_REQ*DATA_W-1:0] req_y,
   output logic [DATA_W-1:0]         add_x,
   output logic [DATA_W-1:0]         add_y,
   input  logic [DATA_W:0]           add_sum,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W:0]           rsp_sum,
   input  logic                      flush,
   output logic                      flush_done,
   output logic                      busy
`ifdef GRANT_CNT_EN
   ,
   output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);

   // Requester count in the width used by the wrap arithmetic, so the
   // candidate index can be reduced without mixed-width compares.
   localparam logic [ID_W:0]   NUM_REQ_W  = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_FLUSHED = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   gnt_id;
   logic              gnt_found;
   logic [ID_W:0]     cand;
   logic              grant_en;
   logic              handshake;
   logic              pipe_empty;
   logic              enter_flushed;

   // Valid and ID shift pipe: stage 0 is loaded on the issue edge, the last
   // stage lines up with the cycle in which add_sum carries that op's result.
   logic [ADD_LAT:0]  pipe_vld;
   logic [ID_W-1:0]   pipe_id [0:ADD_LAT];

   // Decode a requester ID into its one-hot response vector.
   function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

   assign pipe_empty    = (pipe_vld == '0);
   assign busy          = ~pipe_empty;
   assign grant_en      = (state == ST_RUN) && !flush;
   assign handshake     = |(req_valid & req_ready);
   assign enter_flushed = (state == ST_DRAIN) && pipe_empty;

   // Round-robin search: first valid requester at or after the pointer, cyclic.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = {1'b0, ptr} + (ID_W+1)'(off);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end else begin
            cand = cand;
         end
         if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_id    = cand[ID_W-1:0];
         end else begin
            gnt_found = gnt_found;
            gnt_id    = gnt_id;
         end
      end
   end

   // One-hot grant, only while running and not being asked to flush.
   always_comb begin
      req_ready = '0;
      if (grant_en && gnt_found) begin
         req_ready[gnt_id] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Rotate the pointer past the requester that was just served.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (handshake) begin
         if (gnt_id == LAST_ID) begin
            ptr <= '0;
         end else begin
            ptr <= gnt_id + 1'b1;
         end
      end else begin
         ptr <= ptr;
      end
   end

   // Register the granted operands toward the adder; hold them when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_x <= '0;
         add_y <= '0;
      end else if (handshake) begin
         add_x <= req_x[int'(gnt_id)*DATA_W +: DATA_W];
         add_y <= req_y[int'(gnt_id)*DATA_W +: DATA_W];
      end else begin
         add_x <= add_x;
         add_y <= add_y;
      end
   end

   // Carry each op's valid flag and requester ID alongside the adder pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int i = 0; i <= ADD_LAT; i++) begin
            pipe_id[i] <= '0;
         end
      end else begin
         pipe_vld   <= {pipe_vld[ADD_LAT-1:0], handshake};
         pipe_id[0] <= handshake ? gnt_id : '0;
         for (int i = 1; i <= ADD_LAT; i++) begin
            pipe_id[i] <= pipe_id[i-1];
         end
      end
   end

   // Capture the adder result and pulse the owning requester's response bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_sum   <= '0;
      end else if (pipe_vld[ADD_LAT]) begin
         rsp_valid <= id_onehot(pipe_id[ADD_LAT]);
         rsp_sum   <= add_sum;
      end else begin
         rsp_valid <= '0;
         rsp_sum   <= rsp_sum;
      end
   end

   // Run / drain / flushed control with a registered flush_done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RUN;
         flush_done <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               flush_done <= 1'b0;
               if (flush) begin
                  state <= ST_DRAIN;
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               // Keeps draining even if flush drops; only an empty pipe exits.
               if (pipe_empty) begin
                  state      <= ST_FLUSHED;
                  flush_done <= 1'b1;
               end else begin
                  state      <= ST_DRAIN;
                  flush_done <= 1'b0;
               end
            end
            ST_FLUSHED: begin
               flush_done <= 1'b0;
               if (!flush) begin
                  state <= ST_RUN;
               end else begin
                  state <= ST_FLUSHED;
               end
            end
            default: begin
               state      <= ST_RUN;
               flush_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef GRANT_CNT_EN
   // Per-requester wrapping grant counters, cleared when the pipe is flushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
      end else if (enter_flushed) begin
         grant_cnt <= '0;
      end else if (handshake) begin
         grant_cnt[int'(gnt_id)*16 +: 16] <= grant_cnt[int'(gnt_id)*16 +: 16] + 16'd1;
      end else begin
         grant_cnt <= grant_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb
//   Directed bench for adder_share_arb with NUM_REQ=4, DATA_W=64, ADD_LAT=1.
//   Contains a behavioural pipelined adder, a table of per-cycle vectors for
//   arbitration and response routing, and hand-written flush/reset sequences.
//   Build with +define+GRANT_CNT_EN to also exercise the grant counters.
module tb_adder_share_arb;

   localparam int NR  = 4;
   localparam int DW  = 64;
   localparam int LAT = 1;

   logic             clk;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*DW-1:0] req_x;
   logic [NR*DW-1:0] req_y;
   logic [DW-1:0]    add_x;
   logic [DW-1:0]    add_y;
   logic [DW:0]      add_sum;
   logic [NR-1:0]    rsp_valid;
   logic [DW:0]      rsp_sum;
   logic             flush;
   logic             flush_done;
   logic             busy;
`ifdef GRANT_CNT_EN
   logic [NR*16-1:0] grant_cnt;
`endif

   int checks;
   int failures;

   adder_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .ADD_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .add_x      (add_x),
      .add_y      (add_y),
      .add_sum    (add_sum),
      .rsp_valid  (rsp_valid),
      .rsp_sum    (rsp_sum),
      .flush      (flush),
      .flush_done (flush_done),
      .busy       (busy)
`ifdef GRANT_CNT_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural adder with LAT register stages.
   logic [DW:0] sum_pipe [LAT];
   always @(posedge clk) begin
      sum_pipe[0] <= {1'b0, add_x} + {1'b0, add_y};
      for (int i = 1; i < LAT; i++) sum_pipe[i] <= sum_pipe[i-1];
   end
   assign add_sum = sum_pipe[LAT-1];

   typedef struct {
      logic [NR-1:0] valid;
      logic [DW-1:0] xb;
      logic [NR-1:0] exp_ready;
      logic [NR-1:0] exp_rsp;
      logic [DW:0]   exp_sum;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
      req_x[i*DW +: DW] = x;
      req_y[i*DW +: DW] = y;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_x     = '0;
      req_y     = '0;
      flush     = 1'b0;

      // Table: requester i presents x = xb, y = i, so its sum is xb + i.
      // Responses appear three sample points after the granting vector.
      tbl[0]  = '{4'b1111, 64'd100, 4'b0001, 4'b0000, 65'd0};
      tbl[1]  = '{4'b1111, 64'd100, 4'b0010, 4'b0000, 65'd0};
      tbl[2]  = '{4'b1111, 64'd100, 4'b0100, 4'b0000, 65'd0};
      tbl[3]  = '{4'b1111, 64'd100, 4'b1000, 4'b0001, 65'd100};
      tbl[4]  = '{4'b1111, 64'd100, 4'b0001, 4'b0010, 65'd101};
      tbl[5]  = '{4'b0000, 64'd0,   4'b0000, 4'b0100, 65'd102};
      tbl[6]  = '{4'b0001, 64'd200, 4'b0001, 4'b1000, 65'd103};
      tbl[7]  = '{4'b0001, 64'd200, 4'b0001, 4'b0001, 65'd100};
      tbl[8]  = '{4'b0001, 64'd300, 4'b0001, 4'b0000, 65'd0};
      tbl[9]  = '{4'b1001, 64'd400, 4'b1000, 4'b0001, 65'd200};
      tbl[10] = '{4'b1001, 64'd400, 4'b0001, 4'b0001, 65'd200};
      tbl[11] = '{4'b0110, 64'd500, 4'b0010, 4'b0001, 65'd300};
      tbl[12] = '{4'b0101, 64'd500, 4'b0100, 4'b1000, 65'd403};
      tbl[13] = '{4'b0011, 64'd0,   4'b0001, 4'b0001, 65'd400};
      tbl[14] = '{4'b0000, 64'd0,   4'b0000, 4'b0010, 65'd501};
      tbl[15] = '{4'b0000, 64'd0,   4'b0000, 4'b0100, 65'd502};
      tbl[16] = '{4'b0000, 64'd0,   4'b0000, 4'b0001, 65'd0};
      tbl[17] = '{4'b0000, 64'd0,   4'b0000, 4'b0000, 65'd0};

      repeat (2) @(posedge clk);
      next_cyc();
      #1;
      check("rst_add_x", 65'(add_x), 65'd0);
      check("rst_rsp_valid", 65'(rsp_valid), 65'd0);
      check("rst_busy", 65'(busy), 65'd0);
      check("rst_flush_done", 65'(flush_done), 65'd0);
      rst = 1'b0;

      // Single op: req0 5+7.
      next_cyc();
      req_valid = 4'b0001; set_req(0, 64'd5, 64'd7);
      #1 check("single_ready", 65'(req_ready), 65'b0001);
      next_cyc();
      req_valid = '0;
      #1;
      check("single_add_x", 65'(add_x), 65'd5);
      check("single_add_y", 65'(add_y), 65'd7);
      check("single_busy", 65'(busy), 65'd1);
      check("single_rsp_early1", 65'(rsp_valid), 65'd0);
      next_cyc();
      #1 check("single_rsp_early2", 65'(rsp_valid), 65'd0);
      next_cyc();
      #1;
      check("single_rsp_valid", 65'(rsp_valid), 65'b0001);
      check("single_rsp_sum", rsp_sum, 65'd12);
      check("single_busy_idle", 65'(busy), 65'd0);
      next_cyc();
      #1 check("single_rsp_pulse", 65'(rsp_valid), 65'd0);

      // Wide operands on req2 (pointer now 1).
      next_cyc();
      req_valid = 4'b0100; set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      #1 check("wide_ready", 65'(req_ready), 65'b0100);
      next_cyc();
      req_valid = '0;
      next_cyc();
      next_cyc();
      #1;
      check("wide_rsp_valid", 65'(rsp_valid), 65'b0100);
      check("wide_rsp_sum", rsp_sum, 65'h1_FFFF_FFFF_FFFF_FFFE);

      // Flush with two ops in flight (pointer now 3).
      next_cyc();
      req_valid = 4'b0011; set_req(0, 64'd11, 64'd1); set_req(1, 64'd21, 64'd2);
      #1 check("fl_ready0", 65'(req_ready), 65'b0001);
      next_cyc();
      #1 check("fl_ready1", 65'(req_ready), 65'b0010);
      next_cyc();
      flush = 1'b1;
      #1;
      check("fl_suppress", 65'(req_ready), 65'd0);
      check("fl_busy2", 65'(busy), 65'd1);
      next_cyc();
      #1;
      check("fl_rsp_a", 65'(rsp_valid), 65'b0001);
      check("fl_sum_a", rsp_sum, 65'd12);
      check("fl_busy3", 65'(busy), 65'd1);
      check("fl_done3", 65'(flush_done), 65'd0);
      check("fl_ready3", 65'(req_ready), 65'd0);
      next_cyc();
      #1;
      check("fl_rsp_b", 65'(rsp_valid), 65'b0010);
      check("fl_sum_b", rsp_sum, 65'd23);
      check("fl_busy4", 65'(busy), 65'd0);
      check("fl_done4", 65'(flush_done), 65'd0);
      next_cyc();
      #1;
      check("fl_done5", 65'(flush_done), 65'd1);
      check("fl_rsp5", 65'(rsp_valid), 65'd0);
      next_cyc();
      #1;
      check("fl_done6", 65'(flush_done), 65'd0);
      check("fl_ready6", 65'(req_ready), 65'd0);
      next_cyc();
      flush = 1'b0;
      #1 check("fl_ready7", 65'(req_ready), 65'd0);
      next_cyc();
      #1 check("fl_resume_ready", 65'(req_ready), 65'b0001);
      next_cyc();
      req_valid = '0;
      next_cyc();
      next_cyc();
      #1;
      check("fl_resume_rsp", 65'(rsp_valid), 65'b0001);
      check("fl_resume_sum", rsp_sum, 65'd12);

      // flush dropped during DRAIN still completes (pointer now 1).
      next_cyc();
      req_valid = 4'b1000; set_req(3, 64'd30, 64'd3);
      #1 check("fd_ready0", 65'(req_ready), 65'b1000);
      next_cyc();
      req_valid = '0; flush = 1'b1;
      next_cyc();
      flush = 1'b0; req_valid = 4'b0001;
      #1 check("fd_ready2", 65'(req_ready), 65'd0);
      next_cyc();
      #1;
      check("fd_rsp", 65'(rsp_valid), 65'b1000);
      check("fd_sum", rsp_sum, 65'd33);
      check("fd_ready3", 65'(req_ready), 65'd0);
      next_cyc();
      #1;
      check("fd_done", 65'(flush_done), 65'd1);
      check("fd_ready4", 65'(req_ready), 65'd0);
      next_cyc();
      #1 check("fd_resume_ready", 65'(req_ready), 65'b0001);
      next_cyc();
      req_valid = '0;
      repeat (3) next_cyc();

      // Reset with two ops in flight (pointer now 1).
      next_cyc();
      req_valid = 4'b0010; set_req(1, 64'd3, 64'd4);
      next_cyc();
      next_cyc();
      req_valid = '0; rst = 1'b1;
      #1;
      check("rr_add_x", 65'(add_x), 65'd0);
      check("rr_add_y", 65'(add_y), 65'd0);
      check("rr_rsp_valid", 65'(rsp_valid), 65'd0);
      check("rr_rsp_sum", rsp_sum, 65'd0);
      check("rr_flush_done", 65'(flush_done), 65'd0);
      check("rr_busy", 65'(busy), 65'd0);
      next_cyc();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 check("rr_no_rsp", 65'(rsp_valid), 65'd0);
         next_cyc();
      end

      // Table-driven arbitration and routing (pointer is 0 after reset).
      for (int n = 0; n < 18; n++) begin
         next_cyc();
         req_valid = tbl[n].valid;
         for (int i = 0; i < NR; i++) set_req(i, tbl[n].xb, 64'(i));
         #1;
         check($sformatf("tbl%0d_ready", n), 65'(req_ready), 65'(tbl[n].exp_ready));
         check($sformatf("tbl%0d_rsp", n), 65'(rsp_valid), 65'(tbl[n].exp_rsp));
         if (tbl[n].exp_rsp != '0) begin
            check($sformatf("tbl%0d_sum", n), rsp_sum, tbl[n].exp_sum);
         end
      end

`ifdef GRANT_CNT_EN
      // Grant counters: 10 grants to req1, 3 to req3, then flush clears.
      next_cyc();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      #1 check("gc_reset", 65'(grant_cnt), 65'd0);
      for (int k = 0; k < 10; k++) begin
         next_cyc();
         req_valid = 4'b0010;
      end
      for (int k = 0; k < 3; k++) begin
         next_cyc();
         req_valid = 4'b1000;
      end
      next_cyc();
      req_valid = '0;
      #1;
      check("gc_req1", 65'(grant_cnt[16 +: 16]), 65'd10);
      check("gc_req3", 65'(grant_cnt[48 +: 16]), 65'd3);
      check("gc_req0", 65'(grant_cnt[0 +: 16]), 65'd0);
      flush = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            next_cyc();
            #1 if (flush_done) seen = 1'b1;
         end
         check("gc_flush_done_seen", 65'(seen), 65'd1);
      end
      check("gc_cleared", 65'(grant_cnt), 65'd0);
      next_cyc();
      flush = 1'b0;
      repeat (2) next_cyc();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
